slt_serial_compare: RTL and testbench
=====================================

# slt_serial_compare

Multi-cycle set-on-less-than engine that compares two operands and produces the single-bit `lt` flag. In the datapath, `lt` is zero-extended to the 32-bit SLT result word. The block processes the operands LSB-first, `DIGIT` bits per cycle, as a borrow chain. It serves the multi-cycle/area-reduced datapath variant, where a full-width comparator in the ALU is too costly.

## Interface
- `WIDTH`, 32: operand width; must be a multiple of `DIGIT`.
- `DIGIT`, 1: bits consumed per cycle; legal values 1, 2, 4, 8.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request; sampled only in IDLE or DONE.
- `A`  in  WIDTH: left operand; sampled with accepted `start`.
- `B`  in  WIDTH: right operand; sampled with accepted `start`.
- `is_signed`  in  1: 1 selects two's-complement compare (SLT); 0 selects unsigned (SLTU). Sampled with accepted `start`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse; `lt` is valid from this cycle.
- `lt`  out  1: 1 iff A < B under the captured signedness.

## Operation
- States:
  - IDLE: reset state.
  - RUN: iterate over the operand digits.
  - DONE: one cycle only.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE when digit counter reaches N−1, where N = WIDTH/DIGIT.
  - DONE→RUN on `start`; DONE→IDLE otherwise.
- Capture on accepted `start`:
  - Load A into a shift register; load B into a second shift register.
  - If `is_signed`, invert the MSB of both operands. This maps signed order onto unsigned order.
  - Clear `borrow`; clear the counter.
- Each RUN cycle:
  - Compute borrow_out = borrow from (a_digit − b_digit − borrow_in) over the low `DIGIT` bits.
  - Register borrow_out.
  - Shift both registers right by `DIGIT`.
  - Increment the counter.
- Result: on the RUN→DONE edge, `lt` ← final borrow. Final borrow = 1 ⇔ A < B.
- `lt` holds its value through IDLE and subsequent RUN until the next DONE overwrites it.
- `start` while in RUN: ignored. No queuing, no error flag. Operands are not re-sampled.
- Reset:
  - All outputs 0 (`busy`=0, `done`=0, `lt`=0).
  - State IDLE; counter, borrow and shift registers cleared.
  - Reset asserted mid-RUN aborts the operation; no `done` is produced for it.
  - Reset wins over a simultaneous `start`.
- A = B in either mode: `lt`=0.

## Timing
- `start` high in cycle 0 (state IDLE or DONE) → `busy`=1 in cycles 1..N → `done`=1 and new `lt` in cycle N+1.
- Latency: N+1 cycles from start to done (33 for defaults).
- Throughput: one result per N+1 cycles, achieved by asserting `start` during the `done` cycle.
- `busy` and `done` are never high together.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `slt_pkg`:
  - state enum {IDLE, RUN, DONE};
  - default `WIDTH` constant (32);
  - counter-width function clog2(WIDTH/DIGIT).
- Sub-module `slt_borrow_slice`: combinational, `DIGIT`-bit borrow-chain slice (a, b, borrow_in → borrow_out). Instantiated once in the top.
- Top module holds the FSM, counter, shift registers, and output registers.

## Test plan
- Unsigned compare, defaults: A=3, B=5, `is_signed`=0 → `done` at cycle 33, `lt`=1. Then A=5, B=3 → `lt`=0.
- Signed vs unsigned: A=0xFFFFFFFF, B=1.
  - `is_signed`=1 → `lt`=1.
  - Repeated with `is_signed`=0 → `lt`=0.
  - A=B=0x80000000 → `lt`=0 in both modes.
- Back-to-back operation: `start` asserted in every `done` cycle with alternating operands.
  - Results every 33 cycles.
  - `busy` never overlaps `done`.
  - `start` pulses during RUN ignored; the result matches the first-captured operands.
- Reset mid-operation: `reset` asserted in cycle 10 of RUN.
  - Next cycle: `busy`=0, `done`=0, `lt`=0, state IDLE.
  - No `done` follows.
  - A fresh `start` completes normally.
- DIGIT=4 build: A=0x7FFFFFFF, B=0x80000000, `is_signed`=1.
  - `done` at cycle 9.
  - `lt`=0 (A is the larger value).
  - Random 1000-vector sweep matches a reference `$signed`/unsigned compare.

Source files
------------

// File: rtl/slt_pkg.sv
// Shared definitions for the serial set-on-less-than engine.
// Contents: FSM state encoding, default operand width, and the counter
// width helper used to size the digit counter.
package slt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned SLT_WIDTH = 32;

  // clog2(n), floored at 1 so a single-digit configuration still gets a
  // legal one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    for (w = 1; (32'd1 << w) < n; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/slt_borrow_slice.sv
// Combinational DIGIT-bit borrow-chain slice.
// Ports:
//   a, b       in  DIGIT : operand digits (LSB first within the digit)
//   borrow_in  in  1     : borrow from the less significant digit
//   borrow_out out 1     : borrow out of (a - b - borrow_in)
module slt_borrow_slice #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             borrow_in,
  output logic             borrow_out
);

  logic chain;

  // Ripple per bit: borrow when a<b, propagate the incoming borrow when a==b.
  always_comb begin
    chain = borrow_in;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      chain = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain);
    end
    borrow_out = chain;
  end

endmodule

// File: rtl/slt_serial_compare.sv
// Multi-cycle set-on-less-than engine. Operands are consumed LSB-first,
// DIGIT bits per cycle, through a single borrow slice; the final borrow
// is the less-than flag. Signed compares flip both MSBs at capture so
// the unsigned borrow chain yields the two's-complement order.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : request, accepted in IDLE or DONE
//   A, B         : operands, captured with an accepted start
//   is_signed    : 1 = signed (SLT), 0 = unsigned (SLTU), captured with start
//   busy         : high while iterating
//   done         : one-cycle pulse, lt valid from this cycle
//   lt           : A < B under the captured signedness, held until next done
module slt_serial_compare
  import slt_pkg::*;
#(
  parameter int unsigned WIDTH = SLT_WIDTH,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             lt
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] msb_flip;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             borrow_next;
  logic             accept;

  assign msb_flip = {is_signed, {(WIDTH-1){1'b0}}};
  assign accept   = start && ((state == IDLE) || (state == DONE));

  slt_borrow_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a         (a_sh[DIGIT-1:0]),
    .b         (b_sh[DIGIT-1:0]),
    .borrow_in (borrow),
    .borrow_out(borrow_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      lt     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_sh   <= A ^ msb_flip;
            b_sh   <= B ^ msb_flip;
            cnt    <= '0;
            borrow <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          borrow <= borrow_next;
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            lt    <= borrow_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slt_serial_compare.sv
module tb_slt_serial_compare;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start1, start4;
  logic [31:0] a1, b1, a4, b4;
  logic        s1, s4;
  logic        busy1, done1, lt1;
  logic        busy4, done4, lt4;

  bit q1[$];
  bit q4[$];
  int n_vec = 0;
  int n_err = 0;

  slt_serial_compare #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(reset), .start(start1), .A(a1), .B(b1),
    .is_signed(s1), .busy(busy1), .done(done1), .lt(lt1)
  );

  slt_serial_compare #(.WIDTH(32), .DIGIT(4)) u_d4 (
    .clk(clk), .reset(reset), .start(start4), .A(a4), .B(b4),
    .is_signed(s4), .busy(busy4), .done(done4), .lt(lt4)
  );

  // Drive a request at the current (negedge) time and push its expected flag.
  task automatic issue(input bit d4, input logic [31:0] a, input logic [31:0] b,
                       input bit sgn);
    bit exp;
    exp = sgn ? ($signed(a) < $signed(b)) : (a < b);
    if (d4) begin
      a4 = a; b4 = b; s4 = sgn; start4 = 1'b1;
      q4.push_back(exp);
    end else begin
      a1 = a; b1 = b; s1 = sgn; start1 = 1'b1;
      q1.push_back(exp);
    end
  endtask

  // Step negedges until done; cyc = cycle index of done, 0 if never seen.
  task automatic wait_done(input bit d4, input int unsigned limit, input bit noise,
                           output int unsigned cyc, output bit gap, output bit overlap);
    bit got, b, d;
    int unsigned n;
    got = 1'b0; gap = 1'b0; overlap = 1'b0; n = 0;
    while (!got && n < limit) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (d4) start4 = 1'b0; else start1 = 1'b0;
      end
      b = d4 ? busy4 : busy1;
      d = d4 ? done4 : done1;
      if (b && d) overlap = 1'b1;
      if (d) got = 1'b1;
      else if (!b) gap = 1'b1;
      if (noise && !d && !d4) begin
        if (n == 4 || n == 9) begin
          a1 = $urandom; b1 = $urandom; s1 = ~s1; start1 = 1'b1;
        end else if (n == 5 || n == 10) begin
          start1 = 1'b0;
        end
      end
    end
    cyc = got ? n : 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start1 = 1'b0; start4 = 1'b0;
    a1 = '0; b1 = '0; s1 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy1, done1, lt1} !== 3'b000) begin
      n_err++; $display("FAIL reset_d1: got %b want 000", {busy1, done1, lt1});
    end
    n_vec++;
    if ({busy4, done4, lt4} !== 3'b000) begin
      n_err++; $display("FAIL reset_d4: got %b want 000", {busy4, done4, lt4});
    end
    start1 = 1'b1; a1 = 32'd1; b1 = 32'd2;
    @(negedge clk);
    n_vec++;
    if (busy1 !== 1'b0) begin
      n_err++; $display("FAIL reset_beats_start: busy=%b want 0", busy1);
    end
    start1 = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int unsigned cyc; bit gap, ov, exp;
    issue(0, 32'd3, 32'd5, 1'b0);
    wait_done(0, 40, 0, cyc, gap, ov);
    n_vec++;
    if (cyc !== 33) begin n_err++; $display("FAIL latency_d1: got %0d want 33", cyc); end
    n_vec++;
    if (gap !== 1'b0) begin n_err++; $display("FAIL busy_d1: busy dropped before done"); end
    exp = q1.pop_front(); n_vec++;
    if (lt1 !== exp) begin n_err++; $display("FAIL u_3_5: lt=%b want %b", lt1, exp); end
    issue(0, 32'd5, 32'd3, 1'b0);
    wait_done(0, 40, 0, cyc, gap, ov);
    exp = q1.pop_front(); n_vec++;
    if (cyc == 0 || lt1 !== exp) begin
      n_err++; $display("FAIL u_5_3: lt=%b cyc=%0d want %b", lt1, cyc, exp);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (lt1 !== exp || busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_err++; $display("FAIL idle_hold: lt=%b busy=%b done=%b want lt=%b", lt1, busy1, done1, exp);
    end
  endtask

  task automatic test_signed();
    logic [31:0] va [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                            32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] vb [6] = '{32'h1, 32'h1, 32'h8000_0000,
                            32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
    bit          vs [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int unsigned cyc; bit gap, ov, exp;
    for (int i = 0; i < 6; i++) begin
      issue(0, va[i], vb[i], vs[i]);
      wait_done(0, 40, 0, cyc, gap, ov);
      exp = q1.pop_front(); n_vec++;
      if (cyc == 0 || lt1 !== exp) begin
        n_err++;
        $display("FAIL signed_%0d: A=%h B=%h s=%b lt=%b cyc=%0d want %b",
                 i, va[i], vb[i], vs[i], lt1, cyc, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned cyc; bit gap, ov, exp;
    issue(0, 32'h0000_0010, 32'hFFFF_FFF0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      wait_done(0, 40, 1, cyc, gap, ov);
      n_vec++;
      if (cyc !== 33 || gap || ov) begin
        n_err++; $display("FAIL b2b_timing_%0d: cyc=%0d gap=%b overlap=%b want 33/0/0", k, cyc, gap, ov);
      end
      exp = q1.pop_front(); n_vec++;
      if (lt1 !== exp) begin n_err++; $display("FAIL b2b_lt_%0d: lt=%b want %b", k, lt1, exp); end
      if (k < 5) begin
        if (k % 2 == 0) issue(0, 32'hFFFF_FFF0, 32'h0000_0010, 1'b0);
        else            issue(0, 32'h0000_0010, 32'hFFFF_FFF0, 1'b1);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int unsigned cyc; bit gap, ov, exp;
    issue(0, 32'd1, 32'd2, 1'b0);
    wait_done(0, 40, 0, cyc, gap, ov);
    exp = q1.pop_front(); n_vec++;
    if (lt1 !== exp) begin n_err++; $display("FAIL pre_reset_lt: lt=%b want %b", lt1, exp); end
    issue(0, 32'd9, 32'd4, 1'b0);
    wait_done(0, 10, 0, cyc, gap, ov);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q1.delete();
    n_vec++;
    if ({busy1, done1, lt1} !== 3'b000) begin
      n_err++; $display("FAIL mid_reset: busy/done/lt=%b want 000", {busy1, done1, lt1});
    end
    wait_done(0, 40, 0, cyc, gap, ov);
    n_vec++;
    if (cyc !== 0) begin n_err++; $display("FAIL aborted_done: done at %0d want none", cyc); end
    issue(0, 32'd4, 32'd9, 1'b0);
    wait_done(0, 40, 0, cyc, gap, ov);
    exp = q1.pop_front(); n_vec++;
    if (cyc !== 33 || lt1 !== exp) begin
      n_err++; $display("FAIL post_reset: cyc=%0d lt=%b want 33/%b", cyc, lt1, exp);
    end
  endtask

  task automatic test_digit4();
    int unsigned cyc; bit gap, ov, exp;
    logic [31:0] a, b;
    issue(1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    wait_done(1, 20, 0, cyc, gap, ov);
    n_vec++;
    if (cyc !== 9 || gap || ov) begin
      n_err++; $display("FAIL latency_d4: cyc=%0d gap=%b overlap=%b want 9/0/0", cyc, gap, ov);
    end
    exp = q4.pop_front(); n_vec++;
    if (lt4 !== exp) begin n_err++; $display("FAIL d4_max_min: lt=%b want %b", lt4, exp); end
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      if (i % 7 == 0)      b = a;
      else if (i % 5 == 0) b = a ^ (32'd1 << $urandom_range(31, 0));
      else                 b = $urandom;
      issue(1, a, b, 1'($urandom_range(1, 0)));
      wait_done(1, 20, 0, cyc, gap, ov);
      exp = q4.pop_front(); n_vec++;
      if (cyc !== 9 || lt4 !== exp) begin
        n_err++; $display("FAIL d4_rand_%0d: A=%h B=%h s=%b lt=%b cyc=%0d want %b",
                          i, a, b, s4, lt4, cyc, exp);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_reset_mid_run();
    test_digit4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
